vga_timing_rgb: RTL and testbench

Generates 640x480@60 VGA raster timing (hsync, vsync, active-video, pixel coordinates) from the 50 MHz fabric clock and drives the 3-bit rgb pins. It sits directly downstream of the colour source (switches, buttons, debug VIO) and in front of the board's VGA connector. It replaces driving rgb straight from the debug core with properly blanked, sync-aligned video.

---
 rtl/vga_timing_rgb.sv | 178 +++++++++++++++++
 tb/tb_vga_timing_rgb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_rgb.sv
// vga_timing_rgb: 640x480@60 VGA raster timing generator with blanked,
// frame-synchronous colour output.
//
// Optional feature macro: VGA_TEST_PATTERN_EN
//   defined   -> test_mode selects 64-pixel-wide vertical colour bars (x[8:6])
//   undefined -> test_mode is ignored; rgb follows the frame-latched colour
//
// Ports:
//   clk          in   fabric clock (50 MHz)
//   rst          in   asynchronous active-low reset
//   en           in   timing enable; low holds raster at origin, blanked
//   color_in     in   requested colour {r,g,b}, sampled once per frame
//   test_mode    in   test pattern select (optional feature only)
//   hsync        out  horizontal sync (SYNC_POL level during pulse)
//   vsync        out  vertical sync (SYNC_POL level during pulse)
//   rgb          out  pixel colour, 000 outside the visible area
//   active       out  high during visible pixels
//   x, y         out  current pixel column / line
//   frame_start  out  one-clk pulse when outputs first show pixel (0,0)
module vga_timing_rgb #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 2,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] color_in,
    input  logic       test_mode,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0] H_ACT_L  = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_L  = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_hc;
    logic [9:0]       r_vc;
    logic [2:0]       r_color;

    logic             r_hsync;
    logic             r_vsync;
    logic [2:0]       r_rgb;
    logic             r_active;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_frame_start;

    logic             w_tick;
    logic             w_h_end;
    logic             w_v_end;
    logic [9:0]       w_hc_nxt;
    logic [9:0]       w_vc_nxt;
    logic             w_active;
    logic             w_hsync;
    logic             w_vsync;
    logic [2:0]       w_pix;
    logic [2:0]       w_rgb;

    // With CLK_DIV = 1 the divider stays at 0 == DIV_LAST, so the tick is constant.
    assign w_tick  = (r_div == DIV_LAST);
    assign w_h_end = (r_hc == H_LAST);
    assign w_v_end = (r_vc == V_LAST);

    // Raster advance and decode of the current (hc, vc) position
    always_comb begin
        w_hc_nxt = w_h_end ? 10'd0 : r_hc + 10'd1;
        w_vc_nxt = r_vc;
        if (w_h_end) begin
            w_vc_nxt = w_v_end ? 10'd0 : r_vc + 10'd1;
        end
        w_active = (r_hc < H_ACT_L) && (r_vc < V_ACT_L);
        w_hsync  = ((r_hc >= HS_BEG) && (r_hc < HS_END)) ? SYNC_POL : ~SYNC_POL;
        w_vsync  = ((r_vc >= VS_BEG) && (r_vc < VS_END)) ? SYNC_POL : ~SYNC_POL;
        w_rgb    = w_active ? w_pix : 3'b000;
    end

`ifdef VGA_TEST_PATTERN_EN
    // Vertical bars 64 pixels wide, repeating every 512 pixels.
    assign w_pix = test_mode ? r_hc[8:6] : r_color;
`else
    logic w_unused_test_mode;
    assign w_unused_test_mode = test_mode;
    assign w_pix = r_color;
`endif

    // Pixel divider and raster counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
            r_hc  <= 10'd0;
            r_vc  <= 10'd0;
        end else if (!en) begin
            r_div <= '0;
            r_hc  <= 10'd0;
            r_vc  <= 10'd0;
        end else if (w_tick) begin
            r_div <= '0;
            r_hc  <= w_hc_nxt;
            r_vc  <= w_vc_nxt;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Colour is captured on the last pixel of the frame so it changes only at (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_color <= 3'b000;
        end else if (en && w_tick && w_h_end && w_v_end) begin
            r_color <= color_in;
        end
    end

    // Output registers: hold between ticks, frame_start is a single-clk pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_rgb         <= 3'b000;
            r_active      <= 1'b0;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_frame_start <= 1'b0;
        end else if (!en) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_rgb         <= 3'b000;
            r_active      <= 1'b0;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_frame_start <= 1'b0;
        end else if (w_tick) begin
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            r_rgb         <= w_rgb;
            r_active      <= w_active;
            r_x           <= r_hc;
            r_y           <= r_vc;
            r_frame_start <= (r_hc == 10'd0) && (r_vc == 10'd0);
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb         = r_rgb;
    assign active      = r_active;
    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_rgb.sv
// Scoreboard bench for vga_timing_rgb: full-width lines (800 pixels) with a
// shortened vertical frame (8 lines) so several frames fit in the run.
module tb_vga_timing_rgb;

    localparam int unsigned VA = 4;
    localparam int unsigned VF = 1;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 1;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] color_in;
    logic       test_mode;
    logic       hsync;
    logic       vsync;
    logic [2:0] rgb;
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;

    vga_timing_rgb #(
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .color_in    (color_in),
        .test_mode   (test_mode),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .active      (active),
        .x           (x),
        .y           (y),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         px;
        int         py;
        logic [6:0] v;   // {hsync, vsync, active, rgb[2:0], frame_start}
    } exp_t;

    exp_t q[$];
    int   n_cmp;
    int   n_err;

    function automatic logic [2:0] exp_rgb(input int xx, input logic [2:0] col, input logic act);
`ifdef VGA_TEST_PATTERN_EN
        logic [9:0] xv;
        xv = 10'(xx);
        if (!act) return 3'b000;
        return xv[8:6];
`else
        if (!act || xx < 0) return 3'b000;
        return col;
`endif
    endfunction

    task automatic push(input int xx, input int yy, input logic hs, input logic vs,
                        input logic act, input logic [2:0] col, input logic fs);
        exp_t e;
        e.px = xx;
        e.py = yy;
        e.v  = {hs, vs, act, exp_rgb(xx, col, act), fs};
        q.push_back(e);
    endtask

    task automatic check(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act_v, act_v, exp_v, exp_v);
        end
    endtask

    task automatic wait_xy(input int xx, input int yy);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(int'(x) == xx && int'(y) == yy) && n < 20000);
        if (n >= 20000) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_xy(%0d,%0d): got timeout required pixel presented", xx, yy);
        end
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 20000);
    endtask

    task automatic wait_q_empty();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_q_empty: got %0d pending required 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: compare when the DUT presents the pixel named by the queue head.
    // A (0,0) entry matches only while frame_start is high, telling it apart
    // from the reset/idle origin.
    initial begin
        int         idle;
        logic [6:0] got;
        idle = 0;
        forever begin
            @(negedge clk);
            if (q.size() == 0) begin
                idle = 0;
            end else if (int'(x) == q[0].px && int'(y) == q[0].py &&
                         (q[0].px != 0 || q[0].py != 0 || frame_start)) begin
                got = {hsync, vsync, active, rgb, frame_start};
                n_cmp++;
                if (got !== q[0].v) begin
                    n_err++;
                    $display("FAIL pix(%0d,%0d): got hs,vs,act,rgb,fs=%b required %b",
                             q[0].px, q[0].py, got, q[0].v);
                end
                void'(q.pop_front());
                idle = 0;
            end else begin
                idle++;
                if (idle > 15000) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pix(%0d,%0d): got never presented required presented",
                             q[0].px, q[0].py);
                    q.delete();
                    idle = 0;
                end
            end
        end
    end

    initial begin
        int n;
        int n_low;
        int n_high;
        int n_act;
        int n_leak;

        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        en        = 1'b1;
        color_in  = 3'b101;
        test_mode = 1'b1;

        #12;
        check("reset_state", 32'({x, y, hsync, vsync, active, rgb, frame_start}),
              32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0}));

        // Frame 0: latched colour is 0
        push(0,   0, 1, 1, 1, 3'b000, 1);
        push(639, 0, 1, 1, 1, 3'b000, 0);
        push(640, 0, 1, 1, 0, 3'b000, 0);
        push(655, 0, 1, 1, 0, 3'b000, 0);
        push(656, 0, 0, 1, 0, 3'b000, 0);
        push(751, 0, 0, 1, 0, 3'b000, 0);
        push(752, 0, 1, 1, 0, 3'b000, 0);
        push(799, 0, 1, 1, 0, 3'b000, 0);
        push(0,   1, 1, 1, 1, 3'b000, 0);
        push(639, 3, 1, 1, 1, 3'b000, 0);
        push(640, 3, 1, 1, 0, 3'b000, 0);
        push(0,   4, 1, 1, 0, 3'b000, 0);
        push(799, 4, 1, 1, 0, 3'b000, 0);
        push(0,   5, 1, 0, 0, 3'b000, 0);
        push(656, 6, 0, 0, 0, 3'b000, 0);
        push(799, 6, 1, 0, 0, 3'b000, 0);
        push(0,   7, 1, 1, 0, 3'b000, 0);
        push(799, 7, 1, 1, 0, 3'b000, 0);
        // Frame 1: colour 101 captured at the end of frame 0
        push(0,   0, 1, 1, 1, 3'b101, 1);
        push(63,  0, 1, 1, 1, 3'b101, 0);
        push(64,  0, 1, 1, 1, 3'b101, 0);
        push(448, 0, 1, 1, 1, 3'b101, 0);
        push(511, 0, 1, 1, 1, 3'b101, 0);
        push(512, 0, 1, 1, 1, 3'b101, 0);
        push(639, 0, 1, 1, 1, 3'b101, 0);
        push(640, 0, 1, 1, 0, 3'b101, 0);
        push(100, 3, 1, 1, 1, 3'b101, 0);
        push(100, 4, 1, 1, 0, 3'b101, 0);

        @(negedge clk);
        rst = 1'b1;
        wait_fs(n);
        check("fs_latency_reset", 32'(n), 32'd2);

        // hsync pulse width and line period in clks
        n = 0;
        while (hsync !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        n_low = 0;
        while (hsync === 1'b0 && n_low < 5000) begin @(negedge clk); n_low++; end
        n_high = 0;
        while (hsync !== 1'b0 && n_high < 5000) begin @(negedge clk); n_high++; end
        check("hsync_low_clks", 32'(n_low), 32'd192);
        check("hsync_period_clks", 32'(n_low + n_high), 32'd1600);

        // vsync pulse width in clks
        n = 0;
        while (vsync !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
        n_low = 0;
        while (vsync === 1'b0 && n_low < 20000) begin @(negedge clk); n_low++; end
        check("vsync_low_clks", 32'(n_low), 32'd3200);

        // One frame: period, active clk count, no colour outside active
        wait_fs(n);
        n = 0;
        n_act = 0;
        n_leak = 0;
        do begin
            @(negedge clk);
            n++;
            if (active === 1'b1) n_act++;
            if (active !== 1'b1 && rgb !== 3'b000) n_leak++;
        end while (!frame_start && n < 20000);
        check("frame_period_clks", 32'(n), 32'd12800);
        check("active_clks_per_frame", 32'(n_act), 32'd5120);
        check("blank_rgb_leaks", 32'(n_leak), 32'd0);
        wait_q_empty();

        // Mid-frame colour change takes effect only at the next frame
        color_in = 3'b010;
        wait_fs(n);
        push(10, 1, 1, 1, 1, 3'b010, 0);
        push(10, 3, 1, 1, 1, 3'b010, 0);
        push(0,  0, 1, 1, 1, 3'b100, 1);
        push(10, 1, 1, 1, 1, 3'b100, 0);
        wait_xy(0, 2);
        color_in = 3'b100;
        wait_q_empty();

        // en low mid-line: idle blanked at origin, restart like reset, colour kept
        wait_xy(400, 1);
        en = 1'b0;
        repeat (10) @(negedge clk);
        check("en_low_state", 32'({x, y, hsync, vsync, active, rgb, frame_start}),
              32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0}));
        push(0,   0, 1, 1, 1, 3'b100, 1);
        push(639, 0, 1, 1, 1, 3'b100, 0);
        push(640, 0, 1, 1, 0, 3'b100, 0);
        en = 1'b1;
        wait_fs(n);
        check("fs_latency_en", 32'(n), 32'd2);
        wait_q_empty();

        // Async reset mid-line: immediate reset values, colour cleared
        wait_xy(300, 1);
        #2;
        rst = 1'b0;
        #1;
        check("reset_async_state", 32'({x, y, hsync, vsync, active, rgb, frame_start}),
              32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0}));
        push(0,   0, 1, 1, 1, 3'b000, 1);
        push(5,   0, 1, 1, 1, 3'b000, 0);
        push(640, 0, 1, 1, 0, 3'b000, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_fs(n);
        check("fs_latency_reset_mid", 32'(n), 32'd2);
        wait_q_empty();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
